muldiv_seq: RTL and testbench

- Multi-cycle sequencer for unsigned RISC-V M-extension ops: MUL, MULHU, DIVU and REMU.
- Drives the shared 32-bit ALU (`alu_in1`, `alu_in2`, `alu_ctrl`, `alu_out`) one iteration per cycle: shift-add for multiply, restoring subtract for divide.
- Sits beside the execute stage.
- Accepts one request via valid/ready and returns one result via valid/ready.

---
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU:
// one shift-add or restoring-subtract step per cycle, valid/ready on both sides.
module muldiv_seq #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4,
   parameter logic [CTRL_W-1:0] ALU_ADD = 4'd0,
   parameter logic [CTRL_W-1:0] ALU_SUB = 4'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [XLEN-1:0]   req_a,
   input  logic [XLEN-1:0]   req_b,
   input  logic              kill,
   output logic [XLEN-1:0]   alu_in1,
   output logic [XLEN-1:0]   alu_in2,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [XLEN-1:0]   alu_out,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic              busy
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q;
   logic [1:0]        op_q;
   logic [XLEN-1:0]   hi_q, lo_q, d_q;
   logic [XLEN-1:0]   hi_d, lo_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              resp_valid_q;
   logic [XLEN-1:0]   resp_data_q;

   logic [XLEN-1:0]   div_t;
   logic              div_b;
   logic [XLEN-1:0]   mul_sum;
   logic              mul_carry;

   // MULHU and REMU return the high half; MUL and DIVU the low half.
   function automatic logic [XLEN-1:0] pick_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] hi,
                                                   input logic [XLEN-1:0] lo);
      return op[0] ? hi : lo;
   endfunction

   assign div_t = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
   assign div_b = hi_q[XLEN-1];

   always_comb begin
      alu_in1  = '0;
      alu_in2  = '0;
      alu_ctrl = ALU_ADD;
      if (state_q == S_RUN) begin
         alu_in2 = d_q;
         if (op_q[1]) begin
            alu_in1  = div_t;
            alu_ctrl = ALU_SUB;
         end else begin
            alu_in1  = hi_q;
         end
      end
   end

   always_comb begin
      mul_sum   = hi_q;
      mul_carry = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (op_q[1]) begin
         // The bit shifted out of hi means the partial remainder already exceeds d.
         if (div_b || (div_t >= d_q)) begin
            hi_d = alu_out;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_d = div_t;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         if (lo_q[0]) begin
            mul_sum   = alu_out;
            mul_carry = (alu_out < hi_q);
         end
         {hi_d, lo_d} = {mul_carry, mul_sum, lo_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         d_q          <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && !kill) begin
                  op_q  <= req_op;
                  hi_q  <= '0;
                  lo_q  <= req_a;
                  d_q   <= req_b;
                  cnt_q <= '0;
                  if (req_op[1] && (req_b == '0)) begin
                     state_q     <= S_DONE;
                     resp_data_q <= (req_op == OP_REMU) ? req_a : '1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (kill) begin
                  state_q <= S_IDLE;
               end else begin
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(XLEN - 1)) begin
                     state_q     <= S_DONE;
                     resp_data_q <= pick_result(op_q, hi_d, lo_d);
                  end
               end
            end
            S_DONE: begin
               // resp_valid follows one edge after the result is registered.
               if (kill || (resp_valid_q && resp_ready)) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
               end else begin
                  resp_valid_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU; expected values are hand-computed.
module tb_muldiv_seq;

   localparam int XLEN = 32;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [1:0] OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready;
   logic [1:0]      req_op;
   logic [XLEN-1:0] req_a, req_b;
   logic            kill;
   logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
   logic [3:0]      alu_ctrl;
   logic            resp_valid, resp_ready;
   logic [XLEN-1:0] resp_data;
   logic            busy;

   int n_vec = 0;
   int n_err = 0;

   muldiv_seq #(.XLEN(XLEN), .CTRL_W(4), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .kill(kill),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .busy(busy)
   );

   assign alu_out = (alu_ctrl == ALU_SUB) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int exp_lat, input string tag);
      int lat;
      bit sub_seen;
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b1;
      chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      sub_seen = 0;
      while (!resp_valid && lat < 100) begin
         if (alu_ctrl == ALU_SUB) sub_seen = 1;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/data"}, resp_data, exp);
      chk({tag, "/sub_used"}, 32'(sub_seen), 32'(op[1] && (b != '0)));
      @(posedge clk); #1;
      chk({tag, "/busy_after"}, 32'(busy), 32'd0);
      chk({tag, "/valid_after"}, 32'(resp_valid), 32'd0);
      chk({tag, "/ready_after"}, 32'(req_ready), 32'd1);
   endtask

   task automatic check_idle_reset(input string tag);
      chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "/busy"}, 32'(busy), 32'd0);
      chk({tag, "/alu_in1"}, alu_in1, 32'd0);
      chk({tag, "/alu_in2"}, alu_in2, 32'd0);
      chk({tag, "/alu_ctrl"}, 32'(alu_ctrl), 32'(ALU_ADD));
   endtask

   initial begin
      int waited;
      bit saw_valid;
      logic [XLEN-1:0] held;

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      kill = 1'b0; resp_ready = 1'b0;
      #1;
      check_idle_reset("reset");
      chk("reset/resp_data", resp_data, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      do_op(OP_MUL,   32'd7,        32'd6,        32'd42,         33, "mul_7x6");
      do_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33, "mulhu_max");
      do_op(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   33, "mul_max");
      do_op(OP_DIVU,  32'd100,      32'd7,        32'd14,         33, "divu_100_7");
      do_op(OP_REMU,  32'd100,      32'd7,        32'd2,          33, "remu_100_7");
      do_op(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   33, "divu_max_1");
      do_op(OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF,   1,  "divu_5_0");
      do_op(OP_REMU,  32'd5,        32'd0,        32'd5,          1,  "remu_5_0");

      // Backpressure in DONE with a competing request waiting.
      @(negedge clk);
      req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      waited = 0;
      while (!resp_valid && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("bp/latency", 32'(waited), 32'd33);
      held = resp_data;
      chk("bp/data", held, 32'd14);
      @(negedge clk);
      req_op = OP_MUL; req_a = 32'd7; req_b = 32'd6; req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp/hold_data", resp_data, held);
         chk("bp/hold_valid", 32'(resp_valid), 32'd1);
         chk("bp/hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk) resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp/idle_after_hs", 32'(req_ready), 32'd1);
      chk("bp/not_accepted_yet", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("bp/accepted_next", 32'(busy), 32'd1);
      req_valid = 1'b0;
      waited = 0;
      while (!resp_valid && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("bp/second_latency", 32'(waited), 32'd33);
      chk("bp/second_data", resp_data, 32'd42);
      @(posedge clk); #1;

      // kill in RUN, then kill taking priority over a request in IDLE.
      @(negedge clk);
      req_op = OP_MUL; req_a = 32'd123; req_b = 32'd456; req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      saw_valid = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (resp_valid) saw_valid = 1;
      end
      @(negedge clk) kill = 1'b1;
      @(posedge clk); #1;
      check_idle_reset("kill");
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk("kill/idle_priority", 32'(busy), 32'd0);
      req_valid = 1'b0; kill = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (resp_valid) saw_valid = 1;
      end
      chk("kill/no_resp", 32'(saw_valid), 32'd0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      saw_valid = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (resp_valid) saw_valid = 1;
      end
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_idle_reset("midrst");
      chk("midrst/resp_data", resp_data, 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (resp_valid) saw_valid = 1;
      end
      chk("midrst/no_resp", 32'(saw_valid), 32'd0);

      do_op(OP_MUL, 32'd3, 32'd3, 32'd9, 33, "mul_3x3");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected completion");
      $fatal(1);
   end

endmodule
